// File: rtl/m_ext_pkg.sv
// ---------------------------------------------------------------------------
// m_ext_pkg
// Shared definitions for the RV32M multiply/divide sequencer:
//   - md_state_t : sequencer FSM states
//   - F3_*       : RV32M funct3 encodings
//   - md_cnt_width() / MD_CNT_W : width of the divider iteration counter
// ---------------------------------------------------------------------------
package m_ext_pkg;

  localparam int MD_D_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } md_state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // One extra bit so the counter can represent the iteration count itself.
  function automatic int md_cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int MD_CNT_W = md_cnt_width(MD_D_WIDTH);

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational iteration of an unsigned restoring divider.
//   rem_i, quo_i : current partial remainder / shifting dividend-quotient
//   divisor_i    : unsigned divisor
//   rem_o, quo_o : values after one shift-compare-subtract step
// ---------------------------------------------------------------------------
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  // The shifted remainder needs W+1 bits: with a divisor above 2^(W-1) it can
  // exceed the W-bit range before the subtraction brings it back.
  logic [W:0] rem_sh;

  always_comb begin
    rem_sh = {rem_i, quo_i[W-1]};
    if (rem_sh >= {1'b0, divisor_i}) begin
      // Difference is below the divisor, so its low W bits are exact.
      rem_o = rem_sh[W-1:0] - divisor_i;
      quo_o = {quo_i[W-2:0], 1'b1};
    end else begin
      rem_o = rem_sh[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
// RV32M execute-stage sequencer. Multiplies go through an external
// combinational multiplier; divides/remainders run on an internal
// D_WIDTH-step restoring divider.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, flush        launch operation / abort (flush wins over start)
//   funct3, rs1, rs2    RV32M operation and operands
//   mul_a, mul_b, mul_op  registered multiplier operands and control
//   mul_res             multiplier combinational result
//   busy                operation in flight (MUL, DIV, FIX)
//   done, result        one-cycle completion pulse, registered result
// ---------------------------------------------------------------------------
module muldiv_ctrl
  import m_ext_pkg::*;
#(
  parameter int D_WIDTH = MD_D_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               flush,
  input  logic [2:0]         funct3,
  input  logic [D_WIDTH-1:0] rs1,
  input  logic [D_WIDTH-1:0] rs2,
  output logic [D_WIDTH-1:0] mul_a,
  output logic [D_WIDTH-1:0] mul_b,
  output logic [1:0]         mul_op,
  input  logic [D_WIDTH-1:0] mul_res,
  output logic               busy,
  output logic               done,
  output logic [D_WIDTH-1:0] result
);

  localparam int CNT_W = md_cnt_width(D_WIDTH);
  localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(D_WIDTH - 1);
  localparam logic [D_WIDTH-1:0] MIN_NEG   = {1'b1, {(D_WIDTH-1){1'b0}}};

  md_state_t          state_q,    state_d;
  logic [D_WIDTH-1:0] mul_a_q,    mul_a_d;
  logic [D_WIDTH-1:0] mul_b_q,    mul_b_d;
  logic [1:0]         mul_op_q,   mul_op_d;
  logic [D_WIDTH-1:0] result_q,   result_d;
  logic [D_WIDTH-1:0] rem_q,      rem_d;
  logic [D_WIDTH-1:0] quo_q,      quo_d;
  logic [D_WIDTH-1:0] dvsr_q,     dvsr_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic               neg_quo_q,  neg_quo_d;
  logic               neg_rem_q,  neg_rem_d;
  logic               is_rem_q,   is_rem_d;

  logic [D_WIDTH-1:0] step_rem, step_quo;

  div_step #(.W(D_WIDTH)) u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Operand decode for a newly launched divide.
  logic               op_signed, div_zero, div_ovf;
  logic [D_WIDTH-1:0] special_res, a_abs, b_abs;

  always_comb begin
    op_signed = ~funct3[0];
    div_zero  = (rs2 == '0);
    div_ovf   = op_signed && (rs1 == MIN_NEG) && (rs2 == '1);
    if (div_zero) special_res = funct3[1] ? rs1 : '1;
    else          special_res = funct3[1] ? '0  : rs1;
    a_abs = (op_signed && rs1[D_WIDTH-1]) ? -rs1 : rs1;
    b_abs = (op_signed && rs2[D_WIDTH-1]) ? -rs2 : rs2;
  end

  // NOTE: every _d starts as its _q (hold) before any branch, so no path
  // through this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_op_d  = mul_op_q;
    result_d  = result_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (!start) begin
            state_d = IDLE;
          end else if (!funct3[2]) begin
            mul_a_d  = rs1;
            mul_b_d  = rs2;
            mul_op_d = funct3[1:0];
            state_d  = MUL;
          end else if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            rem_d     = '0;
            quo_d     = a_abs;
            dvsr_d    = b_abs;
            cnt_d     = '0;
            neg_quo_d = op_signed & (rs1[D_WIDTH-1] ^ rs2[D_WIDTH-1]);
            neg_rem_d = op_signed & rs1[D_WIDTH-1];
            is_rem_d  = funct3[1];
            state_d   = DIV;
          end
        end
        MUL: begin
          result_d = mul_res;
          state_d  = DONE;
        end
        DIV: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) state_d = FIX;
        end
        FIX: begin
          if (is_rem_q) result_d = neg_rem_q ? -rem_q : rem_q;
          else          result_d = neg_quo_q ? -quo_q : quo_q;
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_op_q  <= '0;
      result_q  <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      mul_op_q  <= mul_op_d;
      result_q  <= result_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
    end
  end

  assign mul_a  = mul_a_q;
  assign mul_b  = mul_b_q;
  assign mul_op = mul_op_q;
  assign result = result_q;
  assign busy   = (state_q == MUL) || (state_q == DIV) || (state_q == FIX);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_muldiv_ctrl
// Self-checking bench for muldiv_ctrl. Provides the external multiplier,
// pushes expected {result, latency} on every accepted launch and pops it
// when done is seen.
// ---------------------------------------------------------------------------
module tb_muldiv_ctrl;
  import m_ext_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [2:0]   funct3;
  logic [W-1:0] rs1, rs2, mul_a, mul_b, mul_res, result;
  logic [1:0]   mul_op;
  logic         busy, done;
  logic [63:0]  prod;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] last_res = '0;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  muldiv_ctrl #(.D_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .mul_a(mul_a), .mul_b(mul_b), .mul_op(mul_op),
    .mul_res(mul_res), .busy(busy), .done(done), .result(result)
  );

  // External combinational multiplier.
  always_comb begin
    case (mul_op)
      2'b01:   prod = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
      2'b10:   prod = {{32{mul_a[31]}}, mul_a} * {32'b0, mul_b};
      default: prod = {32'b0, mul_a} * {32'b0, mul_b};
    endcase
    mul_res = (mul_op == 2'b00) ? prod[31:0] : prod[63:32];
  end

  // Reference model of RV32M results and completion latency.
  function automatic exp_t model(input logic [2:0] f, input logic [W-1:0] a, b);
    exp_t e;
    logic signed [W-1:0] sa, sbv;
    logic [63:0] p;
    longint pa, pb;
    sa = a;
    sbv = b;
    pa = longint'(sa);
    pb = longint'(sbv);
    e.lat = 34;
    e.res = '0;
    case (f)
      F3_MUL:    begin e.res = a * b; e.lat = 2; end
      F3_MULH:   begin p = pa * pb; e.res = p[63:32]; e.lat = 2; end
      F3_MULHSU: begin p = pa * longint'({32'b0, b}); e.res = p[63:32]; e.lat = 2; end
      F3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; e.res = p[63:32]; e.lat = 2; end
      default: begin
        if (b == '0) begin
          e.res = f[1] ? a : 32'hFFFF_FFFF;
          e.lat = 1;
        end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.res = f[1] ? 32'h0 : a;
          e.lat = 1;
        end else if (!f[0]) begin
          e.res = f[1] ? (sa % sbv) : (sa / sbv);
        end else begin
          e.res = f[1] ? (a % b) : (a / b);
        end
      end
    endcase
    return e;
  endfunction

  // Drive one start cycle; caller is positioned at a negedge.
  task automatic launch(input logic [2:0] f, input logic [W-1:0] a, b,
                        input bit push, input exp_t e);
    funct3 = f;
    rs1    = a;
    rs2    = b;
    start  = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Bounded wait for done; lat0 is the cycle number of the first negedge.
  task automatic wait_done(input int lat0, output int lat, output bit ok);
    lat = lat0;
    ok  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, mul_op, result, mul_a, mul_b} !== '0) begin
      bad++;
      $display("FAIL reset_outputs busy=%b done=%b mul_op=%b result=%h mul_a=%h mul_b=%h want all 0",
               busy, done, mul_op, result, mul_a, mul_b);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (dut.state_q !== IDLE || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle state=%0d busy=%b want IDLE/0", dut.state_q, busy);
    end
  endtask

  task automatic test_mul();
    exp_t e;
    int lat;
    bit ok;
    launch(F3_MULH, 32'h8000_0000, 32'h8000_0000, 1'b1, model(F3_MULH, 32'h8000_0000, 32'h8000_0000));
    total++;
    if (mul_op !== 2'b01 || mul_a !== 32'h8000_0000 || mul_b !== 32'h8000_0000 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mul_early mul_op=%b a=%h b=%h busy=%b want 01/80000000/80000000/1", mul_op, mul_a, mul_b, busy);
    end
    @(negedge clk);
    total++;
    if (mul_op !== 2'b01 || mul_a !== 32'h8000_0000 || done !== 1'b0) begin
      bad++;
      $display("FAIL mul_late mul_op=%b a=%h done=%b want 01/80000000/0", mul_op, mul_a, done);
    end
    wait_done(2, lat, ok);
    total++;
    if (!ok || sb.size() == 0) begin
      bad++;
      $display("FAIL mul_done no done seen, want done at cycle 2");
    end else begin
      e = sb.pop_front();
      last_res = e.res;
      total++;
      if (result !== e.res || result !== 32'h4000_0000) begin
        bad++;
        $display("FAIL mulh_result got=%h want=40000000", result);
      end
      total++;
      if (lat !== e.lat) begin
        bad++;
        $display("FAIL mulh_latency got=%0d want=%0d", lat, e.lat);
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mul_pulse done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_div();
    logic [2:0]   tf [10] = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU, F3_DIVU, F3_REM, F3_DIV, F3_REM, F3_DIVU, F3_REMU};
    logic [W-1:0] ta [10] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'h1234, 32'h1234,
                              32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] tb [10] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0001};
    logic [W-1:0] tr [10] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234,
                              32'h8000_0000, 32'd0, 32'd1, 32'h7FFF_FFFE};
    int           tl [10] = '{34, 34, 34, 34, 1, 1, 1, 1, 34, 34};
    exp_t e;
    int lat;
    bit ok;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      e.res = tr[i];
      e.lat = tl[i];
      launch(tf[i], ta[i], tb[i], 1'b1, e);
      wait_done(1, lat, ok);
      total++;
      if (!ok || sb.size() == 0) begin
        bad++;
        $display("FAIL div_done[%0d] no done seen, want at cycle %0d", i, tl[i]);
      end else begin
        e = sb.pop_front();
        last_res = e.res;
        total++;
        if (result !== e.res) begin
          bad++;
          $display("FAIL div_result[%0d] f3=%b a=%h b=%h got=%h want=%h", i, tf[i], ta[i], tb[i], result, e.res);
        end
        total++;
        if (lat !== e.lat) begin
          bad++;
          $display("FAIL div_latency[%0d] got=%0d want=%0d", i, lat, e.lat);
        end
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    int lat;
    bit ok;
    logic [2:0] f;
    logic [W-1:0] a, b;
    for (int i = 0; i < 16; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 7) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 28);
      @(negedge clk);
      launch(f, a, b, 1'b1, model(f, a, b));
      wait_done(1, lat, ok);
      total++;
      if (!ok || sb.size() == 0) begin
        bad++;
        $display("FAIL rand_done[%0d] no done seen f3=%b", i, f);
      end else begin
        e = sb.pop_front();
        last_res = e.res;
        total++;
        if (result !== e.res) begin
          bad++;
          $display("FAIL rand_result[%0d] f3=%b a=%h b=%h got=%h want=%h", i, f, a, b, result, e.res);
        end
        total++;
        if (lat !== e.lat) begin
          bad++;
          $display("FAIL rand_latency[%0d] f3=%b got=%0d want=%0d", i, f, lat, e.lat);
        end
      end
    end
  endtask

  task automatic test_flush();
    exp_t e;
    int lat;
    int dones;
    bit ok;
    @(negedge clk);
    launch(F3_DIVU, 32'd1000, 32'd3, 1'b0, model(F3_DIVU, 32'd1000, 32'd3));
    for (int c = 1; c <= 10; c++) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    total++;
    if (dut.state_q !== IDLE || busy !== 1'b0 || done !== 1'b0 || result !== last_res) begin
      bad++;
      $display("FAIL flush_abort state=%0d busy=%b done=%b result=%h want IDLE/0/0/%h",
               dut.state_q, busy, done, result, last_res);
    end
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones != 0 || result !== last_res) begin
      bad++;
      $display("FAIL flush_no_done dones=%0d result=%h want 0/%h", dones, result, last_res);
    end
    // start and flush together: the operation must not be accepted.
    funct3 = F3_MUL; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    dones = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    total++;
    if (dones != 0 || result !== last_res) begin
      bad++;
      $display("FAIL flush_start_wins active_cycles=%0d result=%h want 0/%h", dones, result, last_res);
    end
    e.res = 32'd15;
    e.lat = 2;
    @(negedge clk);
    launch(F3_MUL, 32'd3, 32'd5, 1'b1, e);
    wait_done(1, lat, ok);
    total++;
    if (!ok || sb.size() == 0) begin
      bad++;
      $display("FAIL post_flush_mul no done seen");
    end else begin
      e = sb.pop_front();
      last_res = e.res;
      total++;
      if (result !== e.res || lat !== e.lat) begin
        bad++;
        $display("FAIL post_flush_mul got=%h at %0d want=%h at %0d", result, lat, e.res, e.lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat;
    bit ok;
    e.res = 32'd14;
    e.lat = 34;
    @(negedge clk);
    launch(F3_DIVU, 32'd100, 32'd7, 1'b1, e);
    for (int c = 1; c <= 5; c++) @(negedge clk);
    // Ignored: start while DIV is running.
    funct3 = F3_MULHU; rs1 = 32'd2; rs2 = 32'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(6, lat, ok);
    total++;
    if (!ok || sb.size() == 0) begin
      bad++;
      $display("FAIL b2b_div no done seen");
    end else begin
      e = sb.pop_front();
      total++;
      if (result !== e.res || lat !== e.lat || busy !== 1'b0) begin
        bad++;
        $display("FAIL b2b_div_ignored_start got=%h at %0d busy=%b want=%h at %0d busy=0",
                 result, lat, busy, e.res, e.lat);
      end
    end
    // Launch directly in DONE.
    e.res = 32'hFFFF_FFFE;
    e.lat = 2;
    launch(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, e);
    wait_done(1, lat, ok);
    total++;
    if (!ok || sb.size() == 0) begin
      bad++;
      $display("FAIL b2b_mulhu no done seen");
    end else begin
      e = sb.pop_front();
      total++;
      if (result !== e.res || lat !== e.lat) begin
        bad++;
        $display("FAIL b2b_mulhu got=%h at %0d want=%h at %0d", result, lat, e.res, e.lat);
      end
    end
    // Special-case divide launched in DONE: done on consecutive cycles.
    e.res = 32'h1234;
    e.lat = 1;
    launch(F3_REMU, 32'h1234, 32'h0, 1'b1, e);
    wait_done(1, lat, ok);
    total++;
    if (!ok || sb.size() == 0) begin
      bad++;
      $display("FAIL b2b_special no done seen");
    end else begin
      e = sb.pop_front();
      last_res = e.res;
      total++;
      if (result !== e.res || lat !== e.lat) begin
        bad++;
        $display("FAIL b2b_special got=%h at %0d want=%h at %0d", result, lat, e.res, e.lat);
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL b2b_tail done=%b pending=%0d want 0/0", done, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    launch(F3_DIV, 32'd12345, 32'd67, 1'b0, model(F3_DIV, 32'd12345, 32'd67));
    for (int c = 1; c <= 5; c++) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, mul_op, result, mul_a, mul_b} !== '0 || dut.state_q !== IDLE) begin
      bad++;
      $display("FAIL reset_mid busy=%b done=%b mul_op=%b result=%h mul_a=%h mul_b=%h state=%0d want all 0/IDLE",
               busy, done, mul_op, result, mul_a, mul_b, dut.state_q);
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    total++;
    if (dones != 0 || result !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_quiet active_cycles=%0d result=%h want 0/0", dones, result);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_random();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the RV32M execute stage. It accepts one M-extension operation at a time from the pipeline and shares a single external combinational multiplier. Division and remainder run on an internal 32-step restoring divider. It produces a registered result with a one-cycle `done` pulse, and holds `busy` so the hazard unit can stall the pipeline.

## Interface
- `D_WIDTH`, 32, operand/result width; divider iteration count equals `D_WIDTH`.

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  launch operation (sampled when FSM in IDLE or DONE)
- `flush`  in  1  abort current operation
- `funct3`  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1`  in  D_WIDTH  operand A
- `rs2`  in  D_WIDTH  operand B
- `mul_a`  out  D_WIDTH  registered operand A to multiplier
- `mul_b`  out  D_WIDTH  registered operand B to multiplier
- `mul_op`  out  2  multiplier control (funct3[1:0])
- `mul_res`  in  D_WIDTH  multiplier combinational result
- `busy`  out  1  operation in flight
- `done`  out  1  one-cycle pulse, `result` valid
- `result`  out  D_WIDTH  registered result, held until next completion

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE/DONE + `start`:
  - Latch `funct3`, `rs1`, `rs2`.
  - funct3[2]=0 → MUL. Drive `mul_a`/`mul_b`/`mul_op` from the latched values.
  - funct3[2]=1, special case → DONE directly.
  - Otherwise → DIV.
- MUL: capture `mul_res` into `result` → DONE.
- Special cases:
  - Divisor 0: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - Signed overflow (DIV/REM, dividend 0x8000_0000, divisor 0xFFFF_FFFF): quotient = dividend, remainder = 0.
- DIV entry:
  - Signed ops take absolute values of both operands. Record `neg_q` = sign(rs1) XOR sign(rs2) and `neg_r` = sign(rs1).
  - Clear the partial remainder; counter = 0.
- DIV, one step per cycle:
  - {rem, quo} shift left by one, bringing in the next dividend bit.
  - If rem ≥ divisor: subtract divisor and set the quotient LSB.
  - Counter increments; leave for FIX after step `D_WIDTH`-1.
- FIX: negate quotient if `neg_q` and remainder if `neg_r` (signed ops only). Write the selected value to `result` → DONE.
- DONE: `done`=1 for exactly this cycle. Without a new `start` → IDLE; with `start` the next operation is accepted here (back-to-back).
- `start` in MUL/DIV/FIX is ignored.
- `flush` in any state → IDLE next cycle:
  - `done` is not asserted and `result` is unchanged.
  - `flush` together with `start` in the same cycle: `flush` wins and the operation is not accepted.

## Timing
- `start` is sampled at cycle 0. Completion (`done`=1):
  - MUL*: cycle 2.
  - Special-case DIV/REM: cycle 1.
  - Normal DIV/REM: cycle `D_WIDTH`+2 (34).
- `busy`=1 in MUL, DIV, FIX; 0 in IDLE and DONE. The stall condition upstream is `start | busy`.
- `mul_a`/`mul_b`/`mul_op` are stable for the whole MUL cycle.
- Reset values:
  - State = IDLE.
  - `busy`, `done` = 0.
  - `result`, `mul_a`, `mul_b` = 0; `mul_op` = 00.
  - Counter, internal registers = 0.
- Reset asserted mid-operation aborts immediately with no `done`.

## Structure
- Package `m_ext_pkg`: state enum `md_state_t`, funct3 localparams (`F3_MUL` … `F3_REMU`), width of the iteration counter ($clog2(`D_WIDTH`)+1).
- Sub-module `div_step`: combinational single restoring iteration. Inputs: rem, quo, divisor. Outputs: next rem, next quo. The controller instantiates one copy and registers its outputs.

## Test plan
- MULH 0x8000_0000 × 0x8000_0000 → `result`=0x4000_0000, `done` at cycle 2; `mul_op`=01 during MUL.
- DIV 0xFFFF_FFF9 (−7) / 2 → 0xFFFF_FFFD at cycle 34; REM same operands → 0xFFFF_FFFF; DIVU 100/7 → 14, REMU → 2.
- DIVU 0x1234 / 0 → 0xFFFF_FFFF at cycle 1; REM 0x1234 / 0 → 0x1234; DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000, REM → 0.
- Flush at cycle 10 of a DIV → IDLE at cycle 11, no `done`, `result` keeps its prior value; a following MUL 3×5 → 15 at +2.
- Back-to-back: `start` MULHU 0xFFFF_FFFF×0xFFFF_FFFF asserted in DONE of a prior op → 0xFFFF_FFFE two cycles later; `start` during DIV is ignored.
- `rst` asserted at cycle 5 of a DIV → all outputs 0 immediately, state IDLE, no `done`.
